// File: rtl/stopwatch_pkg.sv
// Shared types, digit moduli and BCD helpers for the MM:SS.hh stopwatch controller.
// Imported by stopwatch_ctrl and bcd_digit_cnt.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int HUND_MOD      = 10;
    localparam int SEC_ONES_MOD  = 10;
    localparam int SEC_TENS_MOD  = 6;
    localparam int MIN_DIGIT_MOD = 10;

    // Value a digit register takes on the next edge; clear has priority over increment.
    function automatic bcd_t bcd_step(input bcd_t q, input logic en, input logic clr,
                                      input int modv);
        bcd_t nxt;
        nxt = q;
        if (clr) begin
            nxt = '0;
        end else if (en) begin
            nxt = (q == bcd_t'(modv - 1)) ? '0 : q + 4'd1;
        end
        return nxt;
    endfunction

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter with synchronous clear and a terminal-count flag.
// The clear input wins over the enable so a whole chain can be zeroed in one edge.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       term
);

    assign term = (q == bcd_t'(MOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= bcd_step(q, en, clr, MOD);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop and lap/reset FSM driving a BCD MM:SS.hh count,
// a lap-capture register and the digit mux feeding the seven-segment path.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_WRAP = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ss_btn,
    input  logic       lr_btn,
    output logic [3:0] hund_ones,
    output logic [3:0] hund_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_hold,
    output logic       overflow
);

    localparam logic [7:0] MIN_LAST = to_bcd2(MIN_WRAP - 1);

    state_t state, state_nxt;
    logic   count_en, lap_load, clear_count;

    bcd_t c_ho, c_ht, c_so, c_st, c_mo, c_mt;
    logic t_ho, t_ht, t_so, t_st, t_mo, t_mt;
    logic en_ht, en_so, en_st, en_mo, en_mt;
    logic min_last, wrap, min_clr;

    bcd_t lap_ho, lap_ht, lap_so, lap_st, lap_mo, lap_mt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start/stop is checked first in every state so it beats a simultaneous lap/reset.
    always_comb begin
        state_nxt   = state;
        lap_load    = 1'b0;
        clear_count = 1'b0;
        count_en    = 1'b0;
        running     = 1'b0;
        lap_hold    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_btn) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                running  = 1'b1;
                count_en = tick;
                if (ss_btn) begin
                    state_nxt = PAUSE;
                end else if (lr_btn) begin
                    state_nxt = LAP;
                    lap_load  = 1'b1;
                end
            end
            LAP: begin
                running  = 1'b1;
                lap_hold = 1'b1;
                count_en = tick;
                if (ss_btn) begin
                    state_nxt = PAUSE;
                end else if (lr_btn) begin
                    state_nxt = RUN;
                end
            end
            PAUSE: begin
                if (ss_btn) begin
                    state_nxt = RUN;
                end else if (lr_btn) begin
                    state_nxt   = IDLE;
                    clear_count = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign en_ht = count_en & t_ho;
    assign en_so = en_ht & t_ht;
    assign en_st = en_so & t_so;
    assign en_mo = en_st & t_st;
    assign en_mt = en_mo & t_mo;

    // At MIN_WRAP=100 the minute pair rolls over naturally at 99; otherwise compare.
    assign min_last = (MIN_WRAP == 100) ? (t_mt & t_mo) : ({c_mt, c_mo} == MIN_LAST);
    assign wrap     = en_mo & min_last;
    assign min_clr  = clear_count | wrap;

    bcd_digit_cnt #(.MOD(HUND_MOD)) u_hund_ones (
        .clk(clk), .rst_n(rst_n), .clr(clear_count), .en(count_en), .q(c_ho), .term(t_ho)
    );
    bcd_digit_cnt #(.MOD(HUND_MOD)) u_hund_tens (
        .clk(clk), .rst_n(rst_n), .clr(clear_count), .en(en_ht), .q(c_ht), .term(t_ht)
    );
    bcd_digit_cnt #(.MOD(SEC_ONES_MOD)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .clr(clear_count), .en(en_so), .q(c_so), .term(t_so)
    );
    bcd_digit_cnt #(.MOD(SEC_TENS_MOD)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .clr(clear_count), .en(en_st), .q(c_st), .term(t_st)
    );
    bcd_digit_cnt #(.MOD(MIN_DIGIT_MOD)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .clr(min_clr), .en(en_mo), .q(c_mo), .term(t_mo)
    );
    bcd_digit_cnt #(.MOD(MIN_DIGIT_MOD)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .clr(min_clr), .en(en_mt), .q(c_mt), .term(t_mt)
    );

    // Lap captures the count's next value so a coincident tick is included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_ho <= '0;
            lap_ht <= '0;
            lap_so <= '0;
            lap_st <= '0;
            lap_mo <= '0;
            lap_mt <= '0;
        end else if (lap_load) begin
            lap_ho <= bcd_step(c_ho, count_en, clear_count, HUND_MOD);
            lap_ht <= bcd_step(c_ht, en_ht, clear_count, HUND_MOD);
            lap_so <= bcd_step(c_so, en_so, clear_count, SEC_ONES_MOD);
            lap_st <= bcd_step(c_st, en_st, clear_count, SEC_TENS_MOD);
            lap_mo <= bcd_step(c_mo, en_mo, min_clr, MIN_DIGIT_MOD);
            lap_mt <= bcd_step(c_mt, en_mt, min_clr, MIN_DIGIT_MOD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear_count) begin
            overflow <= 1'b0;
        end else if (wrap) begin
            overflow <= 1'b1;
        end
    end

    assign hund_ones = lap_hold ? lap_ho : c_ho;
    assign hund_tens = lap_hold ? lap_ht : c_ht;
    assign sec_ones  = lap_hold ? lap_so : c_so;
    assign sec_tens  = lap_hold ? lap_st : c_st;
    assign min_ones  = lap_hold ? lap_mo : c_mo;
    assign min_tens  = lap_hold ? lap_mt : c_mt;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: two instances (MIN_WRAP 60 and 2) share stimulus
// and are compared against an integer-hundredths reference model.
module tb_stopwatch_ctrl;

    localparam int WRAP_A = 60;
    localparam int WRAP_B = 2;

    logic clk = 1'b0;
    logic rst_n, tick, ss_btn, lr_btn;

    logic [3:0] ho_a, ht_a, so_a, st_a, mo_a, mt_a;
    logic [3:0] ho_b, ht_b, so_b, st_b, mo_b, mt_b;
    logic       running_a, lap_hold_a, overflow_a;
    logic       running_b, lap_hold_b, overflow_b;
    logic [23:0] disp_a, disp_b;
    logic [26:0] obs_a, obs_b;

    int n_vec = 0;
    int n_err = 0;

    typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} mode_t;
    mode_t mode;
    int    cnt_a, cnt_b, lap_a, lap_b;
    bit    ovf_a, ovf_b;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MIN_WRAP(WRAP_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ss_btn(ss_btn), .lr_btn(lr_btn),
        .hund_ones(ho_a), .hund_tens(ht_a), .sec_ones(so_a), .sec_tens(st_a),
        .min_ones(mo_a), .min_tens(mt_a),
        .running(running_a), .lap_hold(lap_hold_a), .overflow(overflow_a)
    );

    stopwatch_ctrl #(.MIN_WRAP(WRAP_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ss_btn(ss_btn), .lr_btn(lr_btn),
        .hund_ones(ho_b), .hund_tens(ht_b), .sec_ones(so_b), .sec_tens(st_b),
        .min_ones(mo_b), .min_tens(mt_b),
        .running(running_b), .lap_hold(lap_hold_b), .overflow(overflow_b)
    );

    assign disp_a = {mt_a, mo_a, st_a, so_a, ht_a, ho_a};
    assign disp_b = {mt_b, mo_b, st_b, so_b, ht_b, ho_b};
    assign obs_a  = {disp_a, running_a, lap_hold_a, overflow_a};
    assign obs_b  = {disp_b, running_b, lap_hold_b, overflow_b};

    function automatic logic [23:0] to_disp(input int v);
        int h, s, m;
        h = v % 100;
        s = (v / 100) % 60;
        m = v / 6000;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    function automatic logic [26:0] exp_a();
        bit run;
        run = (mode == M_RUN) || (mode == M_LAP);
        return {to_disp(mode == M_LAP ? lap_a : cnt_a), run, mode == M_LAP, ovf_a};
    endfunction

    function automatic logic [26:0] exp_b();
        bit run;
        run = (mode == M_RUN) || (mode == M_LAP);
        return {to_disp(mode == M_LAP ? lap_b : cnt_b), run, mode == M_LAP, ovf_b};
    endfunction

    function automatic bit digits_legal(input logic [23:0] d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (d[15:12] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    // Reference model: the count is plain hundredths modulo MIN_WRAP minutes.
    task automatic model_step(input bit t, input bit s, input bit l, input bit r);
        int  na, nb;
        bit  counting;
        if (!r) begin
            mode = M_IDLE;
            cnt_a = 0; cnt_b = 0; lap_a = 0; lap_b = 0;
            ovf_a = 0; ovf_b = 0;
            return;
        end
        counting = t && (mode == M_RUN || mode == M_LAP);
        na = counting ? cnt_a + 1 : cnt_a;
        nb = counting ? cnt_b + 1 : cnt_b;
        if (na == WRAP_A * 6000) begin na = 0; ovf_a = 1; end
        if (nb == WRAP_B * 6000) begin nb = 0; ovf_b = 1; end
        if (s) begin
            case (mode)
                M_IDLE:  mode = M_RUN;
                M_RUN:   mode = M_PAUSE;
                M_LAP:   mode = M_PAUSE;
                M_PAUSE: mode = M_RUN;
                default: mode = M_IDLE;
            endcase
        end else if (l) begin
            case (mode)
                M_RUN: begin mode = M_LAP; lap_a = na; lap_b = nb; end
                M_LAP: mode = M_RUN;
                M_PAUSE: begin mode = M_IDLE; na = 0; nb = 0; ovf_a = 0; ovf_b = 0; end
                default: ;
            endcase
        end
        cnt_a = na;
        cnt_b = nb;
    endtask

    task automatic applyStimulus(input bit t, input bit s, input bit l, input bit r);
        tick = t; ss_btn = s; lr_btn = l; rst_n = r;
        @(posedge clk);
        model_step(t, s, l, r);
        #1;
        tick = 0; ss_btn = 0; lr_btn = 0; rst_n = 1;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0);
        n_vec++;
        if (obs_a !== 27'd0) begin
            n_err++;
            $display("[TB] FAIL reset_a: got %h expected %h", obs_a, 27'd0);
        end
        n_vec++;
        if (obs_b !== 27'd0) begin
            n_err++;
            $display("[TB] FAIL reset_b: got %h expected %h", obs_b, 27'd0);
        end
    endtask

    task automatic test_basic_count();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1, 0, 0, 1);
            repeat (3) applyStimulus(0, 0, 0, 1);
        end
        n_vec++;
        if (disp_a !== 24'h000150 || running_a !== 1'b1 || lap_hold_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL basic_count: got %h run=%b lap=%b expected 000150 run=1 lap=0",
                     disp_a, running_a, lap_hold_a);
        end
        n_vec++;
        if (obs_a !== exp_a()) begin
            n_err++;
            $display("[TB] FAIL basic_model: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_sec_carry();
        int bad;
        bad = 0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(1, 0, 0, 1);
            n_vec++;
            if (!digits_legal(disp_a) || obs_a !== exp_a()) begin
                n_err++;
                if (bad < 5) $display("[TB] FAIL carry_step%0d: got %h expected %h", i, obs_a, exp_a());
                bad++;
            end
        end
        n_vec++;
        if (disp_a !== 24'h010000) begin
            n_err++;
            $display("[TB] FAIL carry_minute: got %h expected 010000", disp_a);
        end
    endtask

    task automatic test_lap();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        repeat (237) applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 1, 1);
        n_vec++;
        if (disp_a !== 24'h000238 || lap_hold_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL lap_capture: got %h lap=%b expected 000238 lap=1", disp_a, lap_hold_a);
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1, 0, 0, 1);
            n_vec++;
            if (disp_a !== 24'h000238) begin
                n_err++;
                $display("[TB] FAIL lap_frozen: got %h expected 000238", disp_a);
            end
        end
        applyStimulus(0, 0, 1, 1);
        n_vec++;
        if (disp_a !== 24'h000338 || lap_hold_a !== 1'b0 || running_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL lap_release: got %h lap=%b run=%b expected 000338 lap=0 run=1",
                     disp_a, lap_hold_a, running_a);
        end
    endtask

    task automatic test_pause();
        applyStimulus(1, 1, 0, 1);
        n_vec++;
        if (disp_a !== 24'h000339 || running_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL pause_tick: got %h run=%b expected 000339 run=0", disp_a, running_a);
        end
        repeat (20) applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 1, 0, 1);
        n_vec++;
        if (disp_a !== 24'h000339 || running_a !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL pause_resume: got %h run=%b expected 000339 run=1", disp_a, running_a);
        end
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1);
        n_vec++;
        if (obs_a !== 27'd0) begin
            n_err++;
            $display("[TB] FAIL pause_clear: got %h expected %h", obs_a, 27'd0);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        repeat (50) applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 1, 1, 1);
        n_vec++;
        if (disp_a !== 24'h000050 || running_a !== 1'b0 || lap_hold_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL ss_lr_same: got %h run=%b lap=%b expected 000050 run=0 lap=0",
                     disp_a, running_a, lap_hold_a);
        end
        applyStimulus(0, 1, 0, 1);
        repeat (4462) applyStimulus(1, 0, 0, 1);
        n_vec++;
        if (disp_a !== 24'h004512) begin
            n_err++;
            $display("[TB] FAIL pre_reset: got %h expected 004512", disp_a);
        end
        applyStimulus(1, 0, 0, 0);
        n_vec++;
        if (obs_a !== 27'd0 || obs_b !== 27'd0) begin
            n_err++;
            $display("[TB] FAIL mid_run_reset: got %h / %h expected 0", obs_a, obs_b);
        end
    endtask

    task automatic test_wrap();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        repeat (11999) applyStimulus(1, 0, 0, 1);
        n_vec++;
        if (disp_b !== 24'h015999 || overflow_b !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_pre: got %h ovf=%b expected 015999 ovf=0", disp_b, overflow_b);
        end
        applyStimulus(1, 0, 0, 1);
        n_vec++;
        if (disp_b !== 24'h000000 || overflow_b !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL wrap_b: got %h ovf=%b expected 000000 ovf=1", disp_b, overflow_b);
        end
        n_vec++;
        if (disp_a !== 24'h020000 || overflow_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL nowrap_a: got %h ovf=%b expected 020000 ovf=0", disp_a, overflow_a);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1);
            n_vec++;
            if (overflow_b !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL ovf_sticky%0d: got %b expected 1", i, overflow_b);
            end
        end
        applyStimulus(0, 0, 1, 1);
        n_vec++;
        if (obs_b !== 27'd0) begin
            n_err++;
            $display("[TB] FAIL ovf_clear: got %h expected %h", obs_b, 27'd0);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(1) == 0, $urandom_range(15) == 0,
                          $urandom_range(15) == 0, $urandom_range(399) != 0);
            n_vec++;
            if (obs_a !== exp_a() || obs_b !== exp_b() ||
                !digits_legal(disp_a) || !digits_legal(disp_b)) begin
                n_err++;
                if (bad < 5) $display("[TB] FAIL random%0d: got %h/%h expected %h/%h",
                                      i, obs_a, obs_b, exp_a(), exp_b());
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 0; tick = 0; ss_btn = 0; lr_btn = 0;
        mode = M_IDLE;
        cnt_a = 0; cnt_b = 0; lap_a = 0; lap_b = 0; ovf_a = 0; ovf_b = 0;
        test_reset();
        test_basic_count();
        test_sec_carry();
        test_lap();
        test_pause();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the hundredth-second tick from the 19-bit divider (1 clk pulse every 500,000 clk at 50 MHz).
- Runs a BCD stopwatch MM:SS.hh from that tick.
- Start/stop and lap/reset are driven from two pre-conditioned button pulses.
- Feeds the seven-segment display path with six BCD digits plus status flags.

Parameters:
- MIN_WRAP, 60: minute count wraps to 00 at this value. Legal range 1..100; stored and compared as two BCD digits.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  hundredth-second pulse, 1 clk wide
- ss_btn  in  1  start/stop request, 1 clk pulse (already debounced and edge-detected)
- lr_btn  in  1  lap/reset request, 1 clk pulse (same conditioning)
- hund_ones, hund_tens  out  4 each  displayed hundredths, BCD
- sec_ones, sec_tens  out  4 each  displayed seconds, BCD
- min_ones, min_tens  out  4 each  displayed minutes, BCD
- running  out  1  high in RUN or LAP
- lap_hold  out  1  high in LAP (display frozen)
- overflow  out  1  sticky; set on minute wrap

Behaviour:
- Single clock domain. All state updates on posedge clk.
- Reset:
  - rst_n low at a clock edge puts state in IDLE.
  - Count registers and lap registers go to 0.
  - All outputs read 0 the following cycle.
  - Reset overrides every other input. Reset mid-run discards the count.
- FSM states: IDLE, RUN, LAP, PAUSE.
  - IDLE: ss -> RUN; lr -> IDLE (no effect).
  - RUN: ss -> PAUSE; lr -> LAP, with lap register loaded.
  - LAP: lr -> RUN (display goes live); ss -> PAUSE (display goes live).
  - PAUSE: ss -> RUN; lr -> IDLE, with count and overflow cleared.
- Simultaneous ss and lr: ss wins; lr is ignored that cycle.
- Counting:
  - On a clock edge with tick=1 and current (registered) state RUN or LAP, the count increments by 0.01 s.
  - Digit chain and moduli:
    - hund_ones mod 10
    - hund_tens mod 10
    - sec_ones mod 10
    - sec_tens mod 6
    - minutes mod MIN_WRAP as a BCD pair
  - Each stage advances only when all lower stages are at their terminal value.
- Ties between tick and transitions:
  - Tick coinciding with ss in RUN still counts (the decision uses current state).
  - Tick coinciding with ss in PAUSE is not counted.
- Wrap:
  - Tick at MIN_WRAP-1:59.99 sets the count to 00:00.00 and sets overflow.
  - overflow stays high until rst_n or entry to IDLE.
- Lap capture:
  - The lap register loads the count's next value, including a coincident tick.
  - The frozen display therefore equals what the live display would have shown.
- Display select:
  - Digits come from the lap register when lap_hold=1, else from the count register.
  - This is a mux of registered values, no extra delay.
  - Digits change one clk after the counting edge.
- running and lap_hold decode the registered state. They change one clk after the button edge.
- Digits never exceed their modulus. Every digit is 0..9; sec_tens is 0..5.
- tick while IDLE or PAUSE: ignored.
- Button pulses longer than 1 clk are out of spec. Each high cycle is treated as a new press.

Decomposition:
- stopwatch_pkg holds:
  - state_t enum {IDLE, RUN, LAP, PAUSE}
  - bcd_t typedef (logic [3:0])
  - constants HUND_MOD=10, SEC_TENS_MOD=6
- Sub-module bcd_digit_cnt, parameter MOD:
  - Inputs: clk, rst_n, clr, en.
  - Outputs: q (bcd_t) and term (q==MOD-1).
  - Instantiated for the four sub-minute digits.
- The minute pair uses two instances plus a MIN_WRAP compare in stopwatch_ctrl.

Test Plan:
- Reset then ss, then 150 ticks spaced 4 clk apart -> digits 00:01.50, running=1, lap_hold=0.
- Preload via ticks to 00:59.99, one more tick -> 01:00.00 with no intermediate illegal digit visible on any cycle.
- In RUN at 00:02.37, lr coincident with tick -> lap_hold=1 and display holds 00:02.38. 100 more ticks -> display unchanged. lr -> display 00:03.38.
- ss coincident with tick in RUN -> count advances once and enters PAUSE. Further ticks produce no change. lr -> all digits 0, state IDLE.
- ss and lr in same cycle from RUN -> PAUSE, no lap capture. rst_n low mid-RUN at 00:45.12 -> next cycle all outputs 0, running=0.
- MIN_WRAP=2: run to 01:59.99, one tick -> 00:00.00 and overflow=1. Overflow stays 1 through PAUSE/RUN, clears after lr from PAUSE.
